// File: rtl/mau4_sequencer_pkg.sv
// Shared types and constants for the 4x4 matrix acceleration unit command sequencer.
package mau_pkg;

    localparam int          MATRIX_PAIRS = 8;
    localparam logic [15:0] FP16_ONE     = 16'h3C00;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        MUL_X4 = 2'd1,
        MUL_X2 = 2'd2,
        RSVD   = 2'd3
    } mau_op_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_ADDR,
        S_LD_DATA,
        S_MU_ADDR,
        S_MU_V0,
        S_MU_V1,
        S_MU_WAIT,
        S_RD0,
        S_RD1,
        S_RESP
    } seq_state_t;

endpackage

// File: rtl/mau4_sequencer_if.sv
// Requester-side command, operand and response handshakes of the MAU sequencer.
interface mau4_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_supr;
    logic [15:0] in_infr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [63:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, in_valid, in_supr, in_infr, rsp_ready,
        input  cmd_ready, in_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_supr, in_infr, rsp_ready,
        output cmd_ready, in_ready, rsp_valid, rsp_err, rsp_data
    );

endinterface

// File: rtl/mau4_sequencer.sv
// Command-level sequencer generating the cycle-exact MAU control strobes and bus traffic.
//   state     | meaning
//   IDLE      | accept LOAD / MUL_X4 / MUL_X2 / reserved
//   LD_ADDR   | drive pair index k with set_matrix_address
//   LD_DATA   | wait for operand pair, write it into the matrix
//   MU_ADDR   | select vector slot (address 0)
//   MU_V0/V1  | stream both vector halves under start
//   MU_WAIT   | settle, then wait for any_busy to clear (bounded)
//   RD0/RD1   | read result words into rsp_data
//   RESP      | hold response until accepted
module mau4_sequencer
    import mau_pkg::*;
#(
    parameter int BUSY_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    mau4_sequencer_if.slave        host,
    output logic [15:0]            mau_dbs_o,
    output logic [15:0]            mau_dbi_o,
    output logic                   mau_db_oe,
    input  logic [15:0]            mau_dbs_i,
    input  logic [15:0]            mau_dbi_i,
    output logic                   mau_set_matrix_address,
    output logic                   mau_write_matrix,
    output logic                   mau_start,
    output logic                   mau_use_x2_mode,
    output logic                   mau_read_output,
    input  logic                   mau_any_busy,
    input  logic                   mau_all_busy
);

    localparam int KW = $clog2(MATRIX_PAIRS);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(BUSY_TIMEOUT);

    seq_state_t     state, state_nx;
    mau_op_t        op;
    logic [KW-1:0]  k;
    logic [SW-1:0]  settle_cnt;
    logic [BW-1:0]  busy_cnt;
    logic           rsp_err_q;
    logic [63:0]    rsp_data_q;
    logic           is_x2;
    logic           all_busy_unused;

    assign all_busy_unused = mau_all_busy;
    assign is_x2           = (op == MUL_X2);
    assign host.rsp_err    = rsp_err_q;
    assign host.rsp_data   = rsp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op         <= LOAD;
            k          <= '0;
            settle_cnt <= '0;
            busy_cnt   <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: if (host.cmd_valid) begin
                    op         <= mau_op_t'(host.cmd_op);
                    k          <= '0;
                    rsp_data_q <= '0;
                    rsp_err_q  <= (mau_op_t'(host.cmd_op) == RSVD);
                end
                S_LD_DATA: if (host.in_valid) k <= k + KW'(1);
                S_MU_V1: if (host.in_valid) begin
                    settle_cnt <= SW'(SETTLE_CYCLES);
                    busy_cnt   <= BW'(BUSY_TIMEOUT - 1);
                end
                S_MU_WAIT: begin
                    if (settle_cnt != '0)
                        settle_cnt <= settle_cnt - SW'(1);
                    else if (mau_any_busy) begin
                        if (busy_cnt == '0) rsp_err_q <= 1'b1;
                        else                busy_cnt  <= busy_cnt - BW'(1);
                    end
                end
                S_RD0:  rsp_data_q[31:0]  <= {mau_dbi_i, mau_dbs_i};
                S_RD1:  rsp_data_q[63:32] <= {mau_dbi_i, mau_dbs_i};
                S_RESP: if (host.rsp_ready) rsp_err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx               = state;
        host.cmd_ready         = 1'b0;
        host.in_ready          = 1'b0;
        host.rsp_valid         = 1'b0;
        mau_dbs_o              = '0;
        mau_dbi_o              = '0;
        mau_db_oe              = 1'b0;
        mau_set_matrix_address = 1'b0;
        mau_write_matrix       = 1'b0;
        mau_start              = 1'b0;
        mau_use_x2_mode        = 1'b0;
        mau_read_output        = 1'b0;
        unique case (state)
            S_IDLE: begin
                host.cmd_ready = 1'b1;
                if (host.cmd_valid) begin
                    unique case (mau_op_t'(host.cmd_op))
                        LOAD:           state_nx = S_LD_ADDR;
                        MUL_X4, MUL_X2: state_nx = S_MU_ADDR;
                        default:        state_nx = S_RESP;
                    endcase
                end
            end
            S_LD_ADDR: begin
                mau_db_oe              = 1'b1;
                mau_dbs_o              = 16'(k);
                mau_set_matrix_address = 1'b1;
                state_nx               = S_LD_DATA;
            end
            S_LD_DATA: begin
                host.in_ready = 1'b1;
                if (host.in_valid) begin
                    mau_db_oe        = 1'b1;
                    mau_dbs_o        = host.in_supr;
                    mau_dbi_o        = host.in_infr;
                    mau_write_matrix = 1'b1;
                    state_nx = (k == KW'(MATRIX_PAIRS - 1)) ? S_RESP : S_LD_ADDR;
                end
            end
            S_MU_ADDR: begin
                mau_db_oe              = 1'b1;
                mau_set_matrix_address = 1'b1;
                mau_use_x2_mode        = is_x2;
                state_nx               = S_MU_V0;
            end
            S_MU_V0, S_MU_V1: begin
                host.in_ready   = 1'b1;
                mau_use_x2_mode = is_x2;
                // start only accompanies a real operand; a stall drops it
                if (host.in_valid) begin
                    mau_db_oe = 1'b1;
                    mau_start = 1'b1;
                    mau_dbs_o = host.in_supr;
                    mau_dbi_o = host.in_infr;
                    state_nx  = (state == S_MU_V0) ? S_MU_V1 : S_MU_WAIT;
                end
            end
            S_MU_WAIT: begin
                if (settle_cnt == '0) begin
                    if (!mau_any_busy)        state_nx = S_RD0;
                    else if (busy_cnt == '0)  state_nx = S_RESP;
                end
            end
            S_RD0, S_RD1: begin
                mau_read_output = 1'b1;
                mau_use_x2_mode = is_x2;
                state_nx        = (state == S_RD0) ? S_RD1 : S_RESP;
            end
            S_RESP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
